fetch_stage: RTL

- Instruction-fetch stage that sits directly downstream of PC_Register.
- Issues PC to instruction memory over a req/ack handshake and buffers the returned word in a one-entry skid register.
- Drives the IF/ID pipeline register (INST, ID_PC, ID_RA, ID_valid), which feeds decode and the INST input of PC_Register.
- Generates stall0, which holds PC while a fetch is incomplete or decode is stalled.

---
 rtl/mips_pkg.sv | 18 +
 rtl/if_id_reg.sv | 57 +++++
 rtl/fetch_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: bubble instruction word and fetch FSM encoding.
package mips_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StHold = 2'd2
    } fetch_state_e;

    // True on cycles where decode accepts a new instruction and PC may move.
    function automatic logic fetch_advance(fetch_state_e state, logic ack, logic stall);
        return ((state == StReq) && ack && !stall) || ((state == StHold) && !stall);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load and bubble controls; async active-low clear.
module if_id_reg #(
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = '0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load_i,
    input  logic              bubble_i,
    input  logic [DATA_W-1:0] inst_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] ra_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] ra_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] inst_q, inst_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ra_q, ra_d;
    logic              valid_q, valid_d;

    always_comb begin
        inst_d  = inst_q;
        pc_d    = pc_q;
        ra_d    = ra_q;
        valid_d = valid_q;
        if (load_i) begin
            // A bubble still records PC/RA so the slot remains traceable.
            inst_d  = bubble_i ? NOP_INST : inst_i;
            valid_d = !bubble_i;
            pc_d    = pc_i;
            ra_d    = ra_i;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            inst_q  <= NOP_INST;
            pc_q    <= '0;
            ra_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            ra_q    <= ra_d;
            valid_q <= valid_d;
        end
    end

    assign inst_o  = inst_q;
    assign pc_o    = pc_q;
    assign ra_o    = ra_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: req/ack to instruction memory, one-entry skid buffer, IF/ID register, stall0.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = mips_pkg::NOP_INST
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] PC,
    input  logic [DATA_W-1:0] RA,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              id_stall,
    input  logic              flush,
    output logic              stall0,
    output logic [DATA_W-1:0] INST,
    output logic [DATA_W-1:0] ID_PC,
    output logic [DATA_W-1:0] ID_RA,
    output logic              ID_valid
);

    fetch_state_e state_q, state_d;

    logic [DATA_W-1:0] skid_inst_q, skid_inst_d;
    logic [DATA_W-1:0] skid_pc_q, skid_pc_d;
    logic [DATA_W-1:0] skid_ra_q, skid_ra_d;

    logic              advance;
    logic              capture;
    logic [DATA_W-1:0] load_inst;
    logic [DATA_W-1:0] load_pc;
    logic [DATA_W-1:0] load_ra;

    always_comb begin
        state_d     = state_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        skid_ra_d   = skid_ra_q;
        advance     = fetch_advance(state_q, imem_ack, id_stall);
        capture     = 1'b0;
        imem_req    = 1'b0;
        load_inst   = imem_rdata;
        load_pc     = PC;
        load_ra     = RA;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                imem_req = 1'b1;
                if (imem_ack && id_stall) begin
                    capture = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                load_inst = skid_inst_q;
                load_pc   = skid_pc_q;
                load_ra   = skid_ra_q;
                if (!id_stall) begin
                    state_d = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (capture) begin
            skid_inst_d = imem_rdata;
            skid_pc_d   = PC;
            skid_ra_d   = RA;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= StIdle;
            skid_inst_q <= NOP_INST;
            skid_pc_q   <= '0;
            skid_ra_q   <= '0;
        end else begin
            state_q     <= state_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
            skid_ra_q   <= skid_ra_d;
        end
    end

    // PC is held until decode takes the word, so the address never moves mid-request.
    assign imem_addr = PC;
    assign stall0    = !advance;

    if_id_reg #(
        .DATA_W   (DATA_W),
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk      (clk),
        .clr      (clr),
        .load_i   (advance),
        .bubble_i (flush),
        .inst_i   (load_inst),
        .pc_i     (load_pc),
        .ra_i     (load_ra),
        .inst_o   (INST),
        .pc_o     (ID_PC),
        .ra_o     (ID_RA),
        .valid_o  (ID_valid)
    );

endmodule
